// File: rtl/weight_buf_loader_if.sv
// Control, weight-stream and bank-write signals of the weight buffer loader.
// master drives the start/stream side; slave is the loader itself.
interface weight_buf_loader_if #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned KERNEL_WIDTH = 72
);
    logic                    i_start;
    logic                    i_abort;
    logic [ADDR_WIDTH-1:0]   i_base_addr;
    logic [ADDR_WIDTH:0]     i_num_groups;
    logic                    s_valid;
    logic [31:0]             s_data;
    logic                    s_ready;
    logic                    o_we;
    logic [ADDR_WIDTH-1:0]   o_addr;
    logic [KERNEL_WIDTH-1:0] o_wdata0;
    logic [KERNEL_WIDTH-1:0] o_wdata1;
    logic [KERNEL_WIDTH-1:0] o_wdata2;
    logic [KERNEL_WIDTH-1:0] o_wdata3;
    logic                    o_busy;
    logic                    o_done;

    modport master (
        output i_start, i_abort, i_base_addr, i_num_groups, s_valid, s_data,
        input  s_ready, o_we, o_addr, o_wdata0, o_wdata1, o_wdata2, o_wdata3, o_busy, o_done
    );

    modport slave (
        input  i_start, i_abort, i_base_addr, i_num_groups, s_valid, s_data,
        output s_ready, o_we, o_addr, o_wdata0, o_wdata1, o_wdata2, o_wdata3, o_busy, o_done
    );
endinterface

// File: rtl/weight_buf_loader.sv
// Packs a 32-bit weight stream into four 72-bit kernels and writes them to one address
// of all four kernel banks per 9 stream words.
module weight_buf_loader #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned KERNEL_WIDTH = 72
) (
    input  logic                clk,
    input  logic                rstn,
    weight_buf_loader_if.slave  bus
);
    localparam int unsigned PackWidth = 4 * KERNEL_WIDTH;
    localparam logic [3:0]  LastWord  = 4'd8;

    typedef enum logic [1:0] {StIdle, StFill, StWrite, StDone} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [ADDR_WIDTH:0]    num_q, num_d;
    logic [3:0]             word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH:0]    grp_cnt_q, grp_cnt_d;
    logic [PackWidth-1:0]   pack_q, pack_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [PackWidth-1:0]   wdata_q, wdata_d;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        word_cnt_d = word_cnt_q;
        grp_cnt_d  = grp_cnt_q;
        pack_d     = pack_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (bus.i_start && !bus.i_abort) begin
                    base_d     = bus.i_base_addr;
                    num_d      = bus.i_num_groups;
                    word_cnt_d = '0;
                    grp_cnt_d  = '0;
                    state_d    = (bus.i_num_groups == '0) ? StDone : StFill;
                end
            end
            StFill: begin
                if (bus.i_abort) begin
                    state_d    = StIdle;
                    word_cnt_d = '0;
                    pack_d     = '0;
                end else if (bus.s_valid) begin
                    pack_d[32*word_cnt_q +: 32] = bus.s_data;
                    word_cnt_d = word_cnt_q + 4'd1;
                    if (word_cnt_q == LastWord) begin
                        // Output registers are loaded here so they stay stable while the
                        // next group refills pack.
                        state_d = StWrite;
                        addr_d  = base_q + grp_cnt_q[ADDR_WIDTH-1:0];
                        wdata_d = pack_d;
                    end
                end
            end
            StWrite: begin
                if (bus.i_abort) begin
                    state_d = StIdle;
                end else if (grp_cnt_q == num_q - 1'b1) begin
                    state_d = StDone;
                end else begin
                    state_d    = StFill;
                    grp_cnt_d  = grp_cnt_q + 1'b1;
                    word_cnt_d = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            base_q     <= '0;
            num_q      <= '0;
            word_cnt_q <= '0;
            grp_cnt_q  <= '0;
            pack_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            word_cnt_q <= word_cnt_d;
            grp_cnt_q  <= grp_cnt_d;
            pack_q     <= pack_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.s_ready  = (state_q == StFill);
    assign bus.o_we     = (state_q == StWrite);
    assign bus.o_busy   = (state_q != StIdle);
    assign bus.o_done   = (state_q == StDone);
    assign bus.o_addr   = addr_q;
    assign bus.o_wdata0 = wdata_q[0*KERNEL_WIDTH +: KERNEL_WIDTH];
    assign bus.o_wdata1 = wdata_q[1*KERNEL_WIDTH +: KERNEL_WIDTH];
    assign bus.o_wdata2 = wdata_q[2*KERNEL_WIDTH +: KERNEL_WIDTH];
    assign bus.o_wdata3 = wdata_q[3*KERNEL_WIDTH +: KERNEL_WIDTH];
endmodule

// File: tb/tb_weight_buf_loader.sv
// Directed and randomized bench for weight_buf_loader; expected bank writes come from
// concatenating the sent stream words per group.
module tb_weight_buf_loader;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    weight_buf_loader_if #(.ADDR_WIDTH(10), .KERNEL_WIDTH(72)) bus ();

    weight_buf_loader #(.ADDR_WIDTH(10), .KERNEL_WIDTH(72)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int n_checks = 0;
    int n_err    = 0;

    int          cycle = 0;
    logic [9:0]   obs_addr[$];
    logic [287:0] obs_data[$];
    int          hs_cnt, done_cnt, ready_in_write, last_we_cycle, last_done_cycle;
    logic [31:0]  wq[$];

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (rstn) begin
            if (bus.o_we) begin
                obs_addr.push_back(bus.o_addr);
                obs_data.push_back({bus.o_wdata3, bus.o_wdata2, bus.o_wdata1, bus.o_wdata0});
                last_we_cycle = cycle;
                if (bus.s_ready) ready_in_write++;
            end
            if (bus.s_valid && bus.s_ready) hs_cnt++;
            if (bus.o_done) begin
                done_cnt++;
                last_done_cycle = cycle;
            end
        end
    end

    task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        obs_addr.delete();
        obs_data.delete();
        hs_cnt = 0;
        done_cnt = 0;
        ready_in_write = 0;
        last_we_cycle = -100;
        last_done_cycle = -100;
    endtask

    task automatic fill_random(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    // Caller is at posedge+1; returns at posedge+1 of the next cycle.
    task automatic do_start(input int base, input int num);
        bus.i_start      = 1'b1;
        bus.i_base_addr  = 10'(base);
        bus.i_num_groups = 11'(num);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
    endtask

    task automatic send_words(input int first, input int n_send, input int duty, input bit noise);
        int sent = 0;
        int budget = 0;
        while (sent < n_send && budget < 3000) begin
            bus.s_valid = ($urandom_range(99) < 32'(duty));
            bus.s_data  = wq[first + sent];
            if (noise) begin
                bus.i_start      = ($urandom_range(2) == 0);
                bus.i_base_addr  = 10'($urandom);
                bus.i_num_groups = 11'($urandom);
            end
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) sent++;
            @(posedge clk); #1;
            budget++;
        end
        bus.s_valid = 1'b0;
        bus.i_start = 1'b0;
        check("stream_budget", 288'(sent), 288'(n_send));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.o_busy !== 1'b0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 288'(bus.o_busy), 288'(0));
    endtask

    // Reference: group g is the concatenation of words 9g..9g+8, word 0 at the LSBs.
    task automatic check_writes(input string tag, input int base, input int num);
        logic [287:0] exp;
        check({tag, "_nwrites"}, 288'(obs_addr.size()), 288'(num));
        for (int g = 0; g < num && g < obs_addr.size(); g++) begin
            exp = '0;
            for (int k = 0; k < 9; k++) exp[32*k +: 32] = wq[9*g + k];
            check({tag, "_addr"}, 288'(obs_addr[g]), 288'((base + g) % 1024));
            check({tag, "_data"}, obs_data[g], exp);
        end
    endtask

    task automatic run_load(input string tag, input int base, input int num, input int duty,
                            input bit noise);
        clear_mon();
        do_start(base, num);
        check({tag, "_ready_after_start"}, 288'(bus.s_ready), 288'(1));
        send_words(0, 9 * num, duty, noise);
        wait_idle({tag, "_idle"});
        check_writes(tag, base, num);
        check({tag, "_done_cnt"}, 288'(done_cnt), 288'(1));
        check({tag, "_done_gap"}, 288'(last_done_cycle - last_we_cycle), 288'(1));
        check({tag, "_hs"}, 288'(hs_cnt), 288'(9 * num));
        check({tag, "_ready_in_write"}, 288'(ready_in_write), 288'(0));
    endtask

    initial begin
        logic [287:0] w;
        bit done_seen;
        bit ready_seen;
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_base_addr = '0;
        bus.i_num_groups = '0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 288'(bus.s_ready), 288'(0));
        check("rst_we", 288'(bus.o_we), 288'(0));
        check("rst_busy", 288'(bus.o_busy), 288'(0));
        check("rst_done", 288'(bus.o_done), 288'(0));
        check("rst_addr", 288'(bus.o_addr), 288'(0));
        check("rst_wdata", {bus.o_wdata3, bus.o_wdata2, bus.o_wdata1, bus.o_wdata0}, 288'(0));
        rstn = 1'b1;
        @(posedge clk); #1;

        // Single group with byte ramp 0x00..0x23
        wq.delete();
        for (int k = 0; k < 9; k++)
            wq.push_back({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        run_load("single", 0, 1, 100, 1'b0);
        if (obs_data.size() > 0) begin
            w = obs_data[0];
            check("single_wdata0", 288'(w[71:0]), 288'(72'h080706050403020100));
            check("single_wdata3", 288'(w[287:216]), 288'(72'h232221201F1E1D1C1B));
        end
        check("hold_addr", 288'(bus.o_addr), 288'(0));

        // Backpressure and wrap-around
        fill_random(27);
        run_load("bp", 5, 3, 50, 1'b0);
        fill_random(18);
        run_load("wrap", 1023, 2, 70, 1'b0);

        // Empty load
        clear_mon();
        done_seen = 1'b0;
        ready_seen = 1'b0;
        do_start(0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.o_done) done_seen = 1'b1;
            if (bus.s_ready) ready_seen = 1'b1;
            if (i == 1) check("num0_done_by2", 288'(done_seen), 288'(1));
            @(posedge clk); #1;
        end
        check("num0_done_cnt", 288'(done_cnt), 288'(1));
        check("num0_ready", 288'(ready_seen), 288'(0));
        check("num0_we", 288'(obs_addr.size()), 288'(0));
        check("num0_busy", 288'(bus.o_busy), 288'(0));

        // Start held through the DONE cycle must not relaunch
        clear_mon();
        do_start(0, 0);
        bus.i_start = 1'b1;
        bus.i_num_groups = 11'd1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        check("start_in_done_busy", 288'(bus.o_busy), 288'(0));
        repeat (2) @(posedge clk);
        #1;
        check("start_in_done_idle", 288'(bus.o_busy), 288'(0));

        // Abort after 4 words, then a clean single-group load
        fill_random(9);
        clear_mon();
        do_start(9, 1);
        send_words(0, 4, 100, 1'b0);
        bus.i_abort = 1'b1;
        bus.s_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_abort = 1'b0;
        bus.s_valid = 1'b0;
        check("abort_ready", 288'(bus.s_ready), 288'(0));
        check("abort_busy", 288'(bus.o_busy), 288'(0));
        repeat (5) @(posedge clk);
        #1;
        check("abort_we", 288'(obs_addr.size()), 288'(0));
        check("abort_done", 288'(done_cnt), 288'(0));
        fill_random(9);
        run_load("after_abort", 9, 1, 100, 1'b0);

        // Start and abort together in IDLE: start ignored
        bus.i_abort = 1'b1;
        do_start(3, 1);
        bus.i_abort = 1'b0;
        check("abort_start_busy", 288'(bus.o_busy), 288'(0));

        // Spurious starts while busy
        fill_random(18);
        run_load("noise", 100, 2, 60, 1'b1);

        // Async reset during group 2 fill, then a clean reload
        fill_random(27);
        clear_mon();
        do_start(200, 3);
        send_words(0, 22, 100, 1'b0);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_ready", 288'(bus.s_ready), 288'(0));
        check("mid_rst_we", 288'(bus.o_we), 288'(0));
        check("mid_rst_busy", 288'(bus.o_busy), 288'(0));
        check("mid_rst_addr", 288'(bus.o_addr), 288'(0));
        check("mid_rst_wdata", {bus.o_wdata3, bus.o_wdata2, bus.o_wdata1, bus.o_wdata0},
              288'(0));
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        clear_mon();
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_we", 288'(obs_addr.size()), 288'(0));
        check("post_rst_done", 288'(done_cnt), 288'(0));
        fill_random(9);
        run_load("reload", 42, 1, 80, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
